// File: rtl/stfft_sched.sv
// stfft_sched: sample scheduler and bin sequencer for the windowed STFFT
// datapath (windowfn + fftmain).
//  - Input side: accepts samples on a valid/ready handshake and re-issues each
//    one as a single-cycle o_ce strobe, with strobes never closer than MIN_GAP
//    cycles apart.
//  - Output side: delays o_ce by OUT_DLY cycles to find the cycles that carry a
//    valid FFT result, and frames that stream into indexed bins using the FFT
//    sync pulse.
// Optional feature macro: STFFT_SCHED_STATS_EN
//  - defined:   o_frame_cnt counts completed frames; o_sync_err is sticky.
//  - undefined: both outputs are tied to 0. An early sync still resynchronises
//               the bin index.
module stfft_sched #(
    parameter int IW       = 14,
    parameter int OW       = 18,
    parameter int FFT_SIZE = 256,
    parameter int MIN_GAP  = 24,
    parameter int OUT_DLY  = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic                        i_sample_valid,
    output logic                        o_sample_ready,
    input  logic [IW-1:0]               i_sample,
    output logic                        o_ce,
    output logic [IW-1:0]               o_sample,
    input  logic [2*OW-1:0]             i_fft_result,
    input  logic                        i_fft_sync,
    output logic                        o_bin_valid,
    output logic [2*OW-1:0]             o_bin,
    output logic [$clog2(FFT_SIZE)-1:0] o_bin_idx,
    output logic                        o_bin_last,
    output logic                        o_sync_err,
    output logic [15:0]                 o_frame_cnt
);

    localparam int IDXW = $clog2(FFT_SIZE);
    localparam int GW   = $clog2(MIN_GAP);
    localparam logic [GW-1:0]   GAP_LOAD = GW'(MIN_GAP - 1);
    localparam logic [GW-1:0]   GAP_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0]   GAP_ONE  = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Input side
    logic [GW-1:0]      gap_cnt_r;
    logic               ce_r;
    logic [IW-1:0]      sample_r;
    logic               ready_s;
    logic               handshake_s;

    // Output side
    logic [OUT_DLY-1:0] ce_sh_r;
    logic               ce_d_s;
    logic               busy_s;
    state_t             state_r;
    state_t             state_s;
    logic [IDXW-1:0]    idx_r;
    logic [IDXW-1:0]    next_idx_s;
    logic               emit_s;
    logic [IDXW-1:0]    emit_idx_s;
    logic               idx_clr_s;
    logic               bin_valid_r;
    logic [2*OW-1:0]    bin_r;
    logic               bin_last_r;

    // Ready is also gated by reset so every output reads 0 while reset is held.
    assign ready_s        = i_reset_n & i_enable & (gap_cnt_r == GAP_ZERO) & ~ce_r;
    assign handshake_s    = ready_s & i_sample_valid;
    assign o_sample_ready = ready_s;
    assign o_ce           = ce_r;
    assign o_sample       = sample_r;

    // Strobe launch, sample hold and gap countdown. The gap counter is loaded
    // on the same edge that raises o_ce, so the strobe cycle counts toward the
    // gap and back-to-back strobes are exactly MIN_GAP cycles apart.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gap_cnt_r <= GAP_ZERO;
            ce_r      <= 1'b0;
            sample_r  <= {IW{1'b0}};
        end else begin
            ce_r <= handshake_s;
            if (handshake_s) begin
                sample_r  <= i_sample;
                gap_cnt_r <= GAP_LOAD;
            end else if (gap_cnt_r != GAP_ZERO) begin
                gap_cnt_r <= gap_cnt_r - GAP_ONE;
            end else begin
                gap_cnt_r <= GAP_ZERO;
            end
        end
    end

    // Delay line of o_ce matching the FFT latency; its tap marks valid results.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ce_sh_r <= {OUT_DLY{1'b0}};
        end else begin
            ce_sh_r[0] <= ce_r;
            for (int k = 1; k < OUT_DLY; k++) begin
                ce_sh_r[k] <= ce_sh_r[k-1];
            end
        end
    end

    assign ce_d_s     = ce_sh_r[OUT_DLY-1];
    // Anything still in flight between o_ce and its FFT result.
    assign busy_s     = ce_r | (|ce_sh_r);
    assign next_idx_s = idx_r + IDX_ONE;

    // Framing FSM: next state, bin emission and resynchronisation decisions.
    always_comb begin
        state_s    = state_r;
        emit_s     = 1'b0;
        emit_idx_s = IDX_ZERO;
        idx_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_enable) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // Results before the first sync are FFT warm-up and are dropped.
                if (ce_d_s && i_fft_sync) begin
                    emit_s     = 1'b1;
                    emit_idx_s = IDX_ZERO;
                    state_s    = ST_STREAM;
                end else if (!i_enable && !busy_s) begin
                    idx_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_STREAM: begin
                if (ce_d_s) begin
                    emit_s = 1'b1;
                    // A sync anywhere but the natural wrap forces bin 0.
                    if (i_fft_sync && (next_idx_s != IDX_ZERO)) begin
                        emit_idx_s = IDX_ZERO;
                    end else begin
                        emit_idx_s = next_idx_s;
                    end
                    state_s = ST_STREAM;
                end else if (!i_enable && !busy_s) begin
                    idx_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            default: begin
                idx_clr_s = 1'b1;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered bin outputs; the index is cleared when the FSM falls back to IDLE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_r       <= IDX_ZERO;
            bin_valid_r <= 1'b0;
            bin_r       <= {(2*OW){1'b0}};
            bin_last_r  <= 1'b0;
        end else begin
            bin_valid_r <= emit_s;
            bin_last_r  <= emit_s & (emit_idx_s == IDX_LAST);
            if (emit_s) begin
                idx_r <= emit_idx_s;
                bin_r <= i_fft_result;
            end else if (idx_clr_s) begin
                idx_r <= IDX_ZERO;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign o_bin_valid = bin_valid_r;
    assign o_bin       = bin_r;
    assign o_bin_idx   = idx_r;
    assign o_bin_last  = bin_last_r;

`ifdef STFFT_SCHED_STATS_EN
    logic [15:0] frame_cnt_r;
    logic        sync_err_r;
    logic        sync_err_evt_s;
    logic        frame_done_s;

    assign sync_err_evt_s = (state_r == ST_STREAM) & ce_d_s & i_fft_sync &
                            (next_idx_s != IDX_ZERO);
    assign frame_done_s   = emit_s & (emit_idx_s == IDX_LAST);

    // Completed-frame counter (wraps) and sticky early-sync flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_cnt_r <= 16'd0;
            sync_err_r  <= 1'b0;
        end else begin
            if (frame_done_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            sync_err_r <= sync_err_r | sync_err_evt_s;
        end
    end

    assign o_frame_cnt = frame_cnt_r;
    assign o_sync_err  = sync_err_r;
`else
    assign o_frame_cnt = 16'd0;
    assign o_sync_err  = 1'b0;
`endif

endmodule

// File: tb/tb_stfft_sched.sv
// tb_stfft_sched: self-checking bench for stfft_sched. A reset/handshake
// vector table is applied first, followed by randomized traffic against a
// frame-level reference model and a stub FFT. The stub answers every o_ce
// OUT_DLY cycles later and asserts sync on its 5th result, then on every
// FFT_SIZE-th result after that.
`timescale 1ns/1ps
module tb_stfft_sched;

    localparam int IW      = 14;
    localparam int OW      = 18;
    localparam int N       = 256;
    localparam int MIN_GAP = 24;
    localparam int OUT_DLY = 1;
    localparam int IDXW    = 8;
`ifdef STFFT_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b1;
    logic              i_enable = 1'b0;
    logic              i_sample_valid = 1'b0;
    logic              o_sample_ready;
    logic [IW-1:0]     i_sample = '0;
    logic              o_ce;
    logic [IW-1:0]     o_sample;
    logic [2*OW-1:0]   i_fft_result = '0;
    logic              i_fft_sync = 1'b0;
    logic              o_bin_valid;
    logic [2*OW-1:0]   o_bin;
    logic [IDXW-1:0]   o_bin_idx;
    logic              o_bin_last;
    logic              o_sync_err;
    logic [15:0]       o_frame_cnt;

    stfft_sched #(.IW(IW), .OW(OW), .FFT_SIZE(N), .MIN_GAP(MIN_GAP), .OUT_DLY(OUT_DLY)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
        .i_sample_valid(i_sample_valid), .o_sample_ready(o_sample_ready),
        .i_sample(i_sample), .o_ce(o_ce), .o_sample(o_sample),
        .i_fft_result(i_fft_result), .i_fft_sync(i_fft_sync),
        .o_bin_valid(o_bin_valid), .o_bin(o_bin), .o_bin_idx(o_bin_idx),
        .o_bin_last(o_bin_last), .o_sync_err(o_sync_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int              cyc = 0;
    int              next_allowed;   // first cycle a new sample may be accepted
    logic            e_ce;           // expected o_ce in the next cycle
    logic [IW-1:0]   e_smp;
    logic            e_bv;
    logic [2*OW-1:0] e_bin;
    int              e_idx;
    logic            e_last;
    logic [7:0]      ce_hist;        // bit k = expected o_ce k cycles ago
    bit              m_synced;
    int              m_idx;
    int              m_frames;
    bit              m_err;
    bit              en_s, vld_s, rand_vld;
    int              stub_pos;       // stub FFT output position; 0 = sync
    bit              force_sync;
    bit              hs_flag;

    task automatic model_reset();
        e_ce = 1'b0; e_smp = '0; e_bv = 1'b0; e_bin = '0; e_idx = 0; e_last = 1'b0;
        ce_hist = '0; m_synced = 1'b0; m_idx = 0; m_frames = 0; m_err = 1'b0;
        next_allowed = 0; stub_pos = -4; force_sync = 1'b0; hs_flag = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        en_s = 1'b0; vld_s = 1'b0;
        i_enable = 1'b0; i_sample_valid = 1'b0; i_fft_sync = 1'b0;
        i_reset_n = 1'b0;
        repeat (ncyc) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic emit(input int idx, input logic [2*OW-1:0] val);
        e_bv   = 1'b1;
        e_bin  = val;
        e_idx  = idx;
        e_last = (idx == N - 1);
        m_idx  = idx;
        if (idx == N - 1) m_frames++;
    endtask

    // One clock cycle: drive inputs and stub FFT, check outputs, advance model.
    task automatic run_cycle();
        logic            exp_ready, sync_v, ce_d, busy;
        logic [63:0]     r64;
        logic [2*OW-1:0] res_v;
        int              nxt;
        @(posedge i_clk);
        #1;
        cyc++;
        if (rand_vld) vld_s = ($urandom_range(0, 3) != 0);
        i_enable       = en_s;
        i_sample_valid = vld_s;
        i_sample       = IW'($urandom);
        ce_hist = {ce_hist[6:0], e_ce};
        ce_d    = ce_hist[OUT_DLY];
        r64     = {$urandom, $urandom};
        res_v   = r64[2*OW-1:0];
        if (ce_d) begin
            sync_v     = force_sync || (stub_pos == 0);
            force_sync = 1'b0;
            if (sync_v) stub_pos = 1;
            else begin
                stub_pos++;
                if (stub_pos == N) stub_pos = 0;
            end
        end else begin
            sync_v = 1'($urandom);   // ignored without a valid result
        end
        i_fft_result = res_v;
        i_fft_sync   = sync_v;
        @(negedge i_clk);
        exp_ready = en_s && (cyc >= next_allowed);
        chk("ready", o_sample_ready, exp_ready);
        chk("ce", o_ce, e_ce);
        chk("sample", o_sample, e_smp);
        chk("bin_valid", o_bin_valid, e_bv);
        if (e_bv) begin
            chk("bin", o_bin, e_bin);
            chk("bin_idx", o_bin_idx, e_idx);
            chk("bin_last", o_bin_last, e_last);
        end
        chk("frame_cnt", o_frame_cnt, STATS ? (m_frames % 65536) : 0);
        chk("sync_err", o_sync_err, STATS ? m_err : 1'b0);
        // model update for this cycle
        hs_flag = exp_ready && vld_s;
        if (hs_flag) begin
            e_smp        = i_sample;
            next_allowed = cyc + MIN_GAP;
        end
        e_ce   = hs_flag;
        e_bv   = 1'b0;
        e_last = 1'b0;
        if (ce_d) begin
            if (!m_synced) begin
                if (sync_v) begin
                    m_synced = 1'b1;
                    emit(0, res_v);
                end
            end else begin
                nxt = (m_idx + 1) % N;
                if (sync_v && nxt != 0) begin
                    m_err = 1'b1;
                    nxt   = 0;
                end
                emit(nxt, res_v);
            end
        end
        busy = |ce_hist[OUT_DLY:0];
        if (!en_s && !busy) begin
            m_synced = 1'b0;
            m_idx    = 0;
        end
    endtask

    typedef struct {
        logic          rst_n, en, vld;
        logic [IW-1:0] smp;
        logic          x_ready, x_ce;
        logic [IW-1:0] x_smp;
    } vec_t;

    vec_t vt[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_ce, cnt, k;
        for (int i = 0; i < 4; i++)
            vt[i] = '{1'b0, 1'($urandom), 1'($urandom), IW'($urandom), 1'b0, 1'b0, 14'h0000};
        vt[4] = '{1'b1, 1'b0, 1'b1, 14'h2AAA, 1'b0, 1'b0, 14'h0000};
        vt[5] = '{1'b1, 1'b1, 1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000};
        vt[6] = '{1'b1, 1'b1, 1'b1, 14'h1234, 1'b1, 1'b0, 14'h0000};
        vt[7] = '{1'b1, 1'b1, 1'b1, 14'h0555, 1'b0, 1'b1, 14'h1234};
        vt[8] = '{1'b1, 1'b0, 1'b1, 14'h0000, 1'b0, 1'b0, 14'h1234};

        #1 i_reset_n = 1'b0;
        model_reset();
        rand_vld = 1'b0;

        // --- table: reset with random inputs, then first handshake ---
        for (int i = 0; i < 9; i++) begin
            @(posedge i_clk);
            #1;
            i_reset_n = vt[i].rst_n; i_enable = vt[i].en;
            i_sample_valid = vt[i].vld; i_sample = vt[i].smp;
            i_fft_sync = 1'b0; i_fft_result = {$urandom, 4'h0};
            @(negedge i_clk);
            chk("tbl_ready", o_sample_ready, vt[i].x_ready);
            chk("tbl_ce", o_ce, vt[i].x_ce);
            chk("tbl_sample", o_sample, vt[i].x_smp);
            chk("tbl_bin_valid", o_bin_valid, 1'b0);
            chk("tbl_bin", o_bin, '0);
            chk("tbl_bin_idx", o_bin_idx, '0);
            chk("tbl_frame_cnt", o_frame_cnt, '0);
            chk("tbl_sync_err", o_sync_err, 1'b0);
        end

        // --- throughput and framing: valid held high for two frames ---
        do_reset(2);
        en_s = 1'b1; vld_s = 1'b1; last_ce = -1;
        for (k = 0; k < 20000 && m_frames < 2; k++) begin
            run_cycle();
            if (o_ce) begin
                if (last_ce >= 0) chk("ce_period", cyc - last_ce, MIN_GAP);
                last_ce = cyc;
            end
        end
        if (m_frames < 2) chk("framing_timeout", m_frames, 2);
        run_cycle();

        // --- early sync at bin 100 ---
        rand_vld = 1'b1;
        for (k = 0; k < 8000 && !(m_synced && m_idx == 99); k++) run_cycle();
        if (!(m_synced && m_idx == 99)) chk("early_sync_timeout", m_idx, 99);
        force_sync = 1'b1;
        cnt = 0;
        for (k = 0; k < 4000 && cnt < 30; k++) begin
            run_cycle();
            if (o_bin_valid) cnt++;
        end
        chk("early_sync_err", o_sync_err, STATS);

        // --- disable right after a handshake ---
        for (k = 0; k < 200 && !hs_flag; k++) run_cycle();
        if (!hs_flag) chk("disable_hs_timeout", hs_flag, 1'b1);
        en_s = 1'b0;
        cnt = 0;
        for (int j = 0; j < 12; j++) begin
            run_cycle();
            if (o_bin_valid) cnt++;
        end
        chk("drain_bins", cnt, 1);
        chk("idle_idx", o_bin_idx, 0);
        en_s = 1'b1;
        stub_pos = -3;
        for (k = 0; k < 8000 && !(m_synced && m_idx == 50); k++) run_cycle();
        if (!(m_synced && m_idx == 50)) chk("reenable_timeout", m_idx, 50);
        run_cycle();

        // --- asynchronous reset mid-frame at bin 50 ---
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_ready", o_sample_ready, 1'b0);
        chk("arst_ce", o_ce, 1'b0);
        chk("arst_sample", o_sample, '0);
        chk("arst_bin_valid", o_bin_valid, 1'b0);
        chk("arst_bin", o_bin, '0);
        chk("arst_bin_idx", o_bin_idx, '0);
        chk("arst_bin_last", o_bin_last, 1'b0);
        chk("arst_frame_cnt", o_frame_cnt, '0);
        chk("arst_sync_err", o_sync_err, 1'b0);
        do_reset(2);
        en_s = 1'b1;
        cnt = 0;
        for (k = 0; k < 4000 && cnt < 3; k++) begin
            run_cycle();
            if (o_bin_valid) cnt++;
        end
        if (cnt < 3) chk("post_reset_timeout", cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
